// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin grant,
// IDLE/EXEC/RESP sequencing, architectural Z/N/C/V flags and one response channel.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OPC_W-1:0]  req0_opcode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_s,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OPC_W-1:0]  req1_opcode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_s,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic              alu_carry,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              alu_v,

    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_c,
    output logic              flag_v
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [OPC_W-1:0] OPC_ARITH_LO = OPC_W'(2);
    localparam logic [OPC_W-1:0] OPC_ARITH_HI = OPC_W'(7);
    localparam logic [OPC_W-1:0] OPC_CMP_LO   = OPC_W'(8);
    localparam logic [OPC_W-1:0] OPC_CMP_HI   = OPC_W'(11);
    localparam logic [OPC_W-1:0] OPC_LAST     = OPC_W'(20);

    state_t              state_q;
    logic                last_grant_q;
    logic                id_q;
    logic                s_q;
    logic [OPC_W-1:0]    op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                fz_q, fn_q, fc_q, fv_q;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_result_q;
    logic [3:0]          rsp_flags_q;

    logic                gnt_vld;
    logic                gnt_id;
    logic                is_cmp;
    logic                is_arith;
    logic                is_ill;
    logic                upd_znc;
    logic                upd_v;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        gnt_vld    = req0_valid | req1_valid;
        gnt_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = (state_q == IDLE) && gnt_vld && !gnt_id;
        req1_ready = (state_q == IDLE) && gnt_vld && gnt_id;
    end

    always_comb begin
        is_cmp   = (op_q >= OPC_CMP_LO) && (op_q <= OPC_CMP_HI);
        is_arith = (op_q >= OPC_ARITH_LO) && (op_q <= OPC_ARITH_HI);
        is_ill   = (op_q > OPC_LAST);
        upd_znc  = !is_ill && (is_cmp || s_q);
        upd_v    = !is_ill && (is_cmp || (is_arith && s_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            s_q          <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            fz_q         <= 1'b0;
            fn_q         <= 1'b0;
            fc_q         <= 1'b0;
            fv_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        op_q         <= gnt_id ? req1_opcode : req0_opcode;
                        a_q          <= gnt_id ? req1_a      : req0_a;
                        b_q          <= gnt_id ? req1_b      : req0_b;
                        s_q          <= gnt_id ? req1_s      : req0_s;
                        id_q         <= gnt_id;
                        last_grant_q <= gnt_id;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    if (is_ill) begin
                        rsp_err_q    <= 1'b1;
                        rsp_result_q <= '0;
                        rsp_flags_q  <= {fz_q, fn_q, fc_q, fv_q};
                    end else begin
                        rsp_err_q    <= 1'b0;
                        rsp_result_q <= is_cmp ? '0 : alu_result;
                        rsp_flags_q  <= {alu_z, alu_n, alu_c, alu_v};
                    end
                    if (upd_znc) begin
                        fz_q <= alu_z;
                        fn_q <= alu_n;
                        fc_q <= alu_c;
                    end
                    if (upd_v) begin
                        fv_q <= alu_v;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = op_q;
    assign alu_carry  = fc_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;

    assign flag_z = fz_q;
    assign flag_n = fn_q;
    assign flag_c = fc_q;
    assign flag_v = fv_q;

endmodule
